// File: rtl/decomp_pkg.sv
// Shared types for the compressed-instruction prefetch path: FSM states,
// the default sequential increment and the tagged queue entry.
package decomp_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_PCADD = 32'h0000_0004;

  typedef enum logic [1:0] {
    S_BOOT,
    S_STREAM,
    S_FLUSH
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] tag;
    logic [XLEN-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/compressed_fetch_buffer_if.sv
// Decompressor-side and instruction-memory-side signals of the prefetch buffer.
// The buffer is the slave; the decompressor/memory environment is the master.
interface compressed_fetch_buffer_if
  import decomp_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
);

  logic [WIDTH-1:0] PCcompress;
  logic             pc_take;
  logic [WIDTH-1:0] NextInstr;
  logic             instr_valid;
  logic             hold;
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_gnt;
  logic             imem_rvalid;
  logic [WIDTH-1:0] imem_rdata;

  modport slave (
    input  PCcompress, pc_take, imem_gnt, imem_rvalid, imem_rdata,
    output NextInstr, instr_valid, hold, imem_req, imem_addr
  );

  modport master (
    output PCcompress, pc_take, imem_gnt, imem_rvalid, imem_rdata,
    input  NextInstr, instr_valid, hold, imem_req, imem_addr
  );

endinterface

// File: rtl/fetch_fifo.sv
// Circular queue of tagged instruction words with one write and one read port.
// A synchronous clear empties it without touching the stored words.
module fetch_fifo
  import decomp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     wr_en_i,
  input  entry_t                   wr_data_i,
  input  logic                     rd_en_i,
  output entry_t                   rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   head_q;
  logic [PW-1:0]   tail_q;
  logic [CW-1:0]   count_q;
  logic            doWrite;
  logic            doRead;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == DEPTH[CW-1:0]);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[head_q];

  // A write into a full queue is accepted only when the head leaves in the same cycle.
  assign doRead  = rd_en_i && !empty_o;
  assign doWrite = wr_en_i && (!full_o || doRead);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (doWrite) begin
        mem_q[tail_q] <= wr_data_i;
        tail_q        <= tail_q + PW'(1);
      end
      if (doRead) begin
        head_q <= head_q + PW'(1);
      end
      if (doWrite && !doRead) begin
        count_q <= count_q + CW'(1);
      end else if (!doWrite && doRead) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/compressed_fetch_buffer.sv
// Prefetch queue feeding the decompressor: fetches sequential words ahead of
// PCcompress, tags them with their address and flushes on any redirect.
module compressed_fetch_buffer
  import decomp_pkg::*;
#(
  parameter int unsigned     WIDTH = XLEN,
  parameter logic [WIDTH-1:0] PCADD = WIDTH'(DEFAULT_PCADD),
  parameter int unsigned     DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  compressed_fetch_buffer_if.slave  bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [WIDTH-1:0] tag;
    logic [WIDTH-1:0] data;
  } entry_t;

  fetch_state_t     state_q, state_d;
  logic [WIDTH-1:0] fetchPc_q, fetchPc_d;
  logic [WIDTH-1:0] rspPc_q, rspPc_d;
  logic [CW-1:0]    outstanding_q, outstanding_d;
  logic [CW-1:0]    discard_q, discard_d;

  entry_t           headEntry;
  entry_t           wrEntry;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [CW-1:0]    fifoCount;
  logic [CW:0]      inFlight;
  logic             streaming;
  logic             tagMatch;
  logic             redirect;
  logic             instrValid;
  logic             imemReq;
  logic             grant;
  logic             rspRetire;
  logic             rspKeep;
  logic             pop;

  // rspPc_q is the tag the next live response will carry; with nothing live in
  // flight it equals fetchPc_q, so it is the expected address for an empty queue.
  assign streaming  = (state_q == S_STREAM);
  assign tagMatch   = (headEntry.tag == bus.PCcompress);
  assign redirect   = streaming && (fifoEmpty ? (rspPc_q != bus.PCcompress) : !tagMatch);
  assign instrValid = streaming && !fifoEmpty && tagMatch;
  assign pop        = instrValid && bus.pc_take;
  assign inFlight   = {1'b0, fifoCount} + {1'b0, outstanding_q};
  assign imemReq    = streaming && !redirect && !fifoFull && (inFlight < DEPTH[CW:0]);
  assign grant      = imemReq && bus.imem_gnt;
  assign rspRetire  = bus.imem_rvalid && (outstanding_q != '0);
  assign rspKeep    = bus.imem_rvalid && streaming && (discard_q == '0);
  assign wrEntry    = '{tag: rspPc_q, data: bus.imem_rdata};

  assign bus.NextInstr   = headEntry.data;
  assign bus.instr_valid = instrValid;
  assign bus.hold        = !instrValid;
  assign bus.imem_req    = imemReq;
  assign bus.imem_addr   = fetchPc_q;

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) uFetchFifo (
    .clk       (clk),
    .rst_n     (reset),
    .clear_i   (state_q == S_FLUSH),
    .wr_en_i   (rspKeep),
    .wr_data_i (wrEntry),
    .rd_en_i   (pop),
    .rd_data_o (headEntry),
    .full_o    (fifoFull),
    .empty_o   (fifoEmpty),
    .count_o   (fifoCount)
  );

  always_comb begin
    state_d       = state_q;
    fetchPc_d     = fetchPc_q;
    rspPc_d       = rspPc_q;
    discard_d     = discard_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(rspRetire);
    case (state_q)
      S_BOOT: begin
        fetchPc_d = bus.PCcompress;
        rspPc_d   = bus.PCcompress;
        state_d   = S_STREAM;
      end
      S_STREAM: begin
        if (grant) fetchPc_d = fetchPc_q + PCADD;
        if (rspKeep) rspPc_d = rspPc_q + PCADD;
        if (bus.imem_rvalid && (discard_q != '0)) discard_d = discard_q - CW'(1);
        if (redirect) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        // A response landing in this cycle is already gone, so it is not counted as stale.
        fetchPc_d = bus.PCcompress;
        rspPc_d   = bus.PCcompress;
        discard_d = outstanding_q - CW'(rspRetire);
        state_d   = S_STREAM;
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_BOOT;
      fetchPc_q     <= '0;
      rspPc_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetchPc_q     <= fetchPc_d;
      rspPc_q       <= rspPc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

endmodule

// File: tb/tb_compressed_fetch_buffer.sv
// Bench for compressed_fetch_buffer: per-cycle vector table, hand-written corner
// sequences and a randomized run checked against an address-indexed memory model.
module tb_compressed_fetch_buffer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  typedef struct {
    bit          doReset;
    logic [31:0] pcStart;
    logic        take;
    logic        gnt;
    logic        expValid;
    logic        expReq;
    logic [31:0] expAddr;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } memReq_t;

  logic clk = 1'b0;
  logic reset;

  compressed_fetch_buffer_if #(.WIDTH(WIDTH)) bus ();

  compressed_fetch_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  memReq_t     memQ[$];
  vec_t        vecs[$];
  int          cyc;
  int          latency;
  int          vectors;
  int          miscompares;
  logic [31:0] pcReg;
  logic [31:0] sPc;
  logic [31:0] sData;
  logic [31:0] sAddr;
  logic        sValid;
  logic        sReq;
  logic        sHold;

  // Every word in memory is a bijective scramble of its own address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic releaseReset(input logic [31:0] pc);
    pcReg = pc;
    bus.PCcompress = pc;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc = 0;
  endtask

  task automatic doReset(input logic [31:0] pc);
    @(posedge clk);
    #1;
    reset = 1'b0;
    memQ.delete();
    bus.pc_take = 1'b0;
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    releaseReset(pc);
  endtask

  // One clock of the decompressor plus in-order memory; returns #1 after the next edge.
  task automatic applyStimulus(input logic take, input logic gnt);
    logic [31:0] nextPc;
    bus.pc_take = take;
    bus.imem_gnt = gnt;
    if (memQ.size() > 0 && memQ[0].ready <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = memWord(memQ[0].addr);
      void'(memQ.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata = $urandom;
    end
    #1;
    sPc = pcReg;
    sValid = bus.instr_valid;
    sData = bus.NextInstr;
    sReq = bus.imem_req;
    sAddr = bus.imem_addr;
    sHold = bus.hold;
    if (sReq && gnt) memQ.push_back('{addr: sAddr, ready: cyc + latency});
    nextPc = (sValid && take) ? pcReg + 32'd4 : pcReg;
    @(posedge clk);
    #1;
    cyc++;
    pcReg = nextPc;
    bus.PCcompress = pcReg;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          seen;
    int          firstValid;
    int          waitCnt;
    int          sinceJump;
    logic        prevReq;
    logic        prevGnt;
    logic [31:0] prevAddr;
    logic        take;
    logic        gnt;

    vectors = 0;
    miscompares = 0;
    reset = 1'b0;
    latency = 1;
    cyc = 0;
    bus.PCcompress = '0;
    bus.pc_take = 1'b0;
    bus.imem_gnt = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata = '0;
    pcReg = '0;

    // Streaming, full-queue and grant-stall timelines on zero-wait memory.
    vecs.push_back('{1, 32'h100, 1, 1, 0, 0, 32'h0});
    vecs.push_back('{0, 32'h0,   1, 1, 0, 1, 32'h100});
    vecs.push_back('{0, 32'h0,   1, 1, 0, 1, 32'h104});
    vecs.push_back('{0, 32'h0,   1, 1, 1, 1, 32'h108});
    vecs.push_back('{0, 32'h0,   1, 1, 1, 1, 32'h10C});
    vecs.push_back('{0, 32'h0,   1, 1, 1, 1, 32'h110});
    vecs.push_back('{0, 32'h0,   1, 1, 1, 1, 32'h114});
    vecs.push_back('{1, 32'h100, 0, 1, 0, 0, 32'h0});
    vecs.push_back('{0, 32'h0,   0, 1, 0, 1, 32'h100});
    vecs.push_back('{0, 32'h0,   0, 1, 0, 1, 32'h104});
    vecs.push_back('{0, 32'h0,   0, 1, 1, 1, 32'h108});
    vecs.push_back('{0, 32'h0,   0, 1, 1, 1, 32'h10C});
    vecs.push_back('{0, 32'h0,   0, 1, 1, 0, 32'h0});
    vecs.push_back('{0, 32'h0,   1, 1, 1, 0, 32'h0});
    vecs.push_back('{0, 32'h0,   0, 1, 1, 1, 32'h110});
    vecs.push_back('{0, 32'h0,   0, 1, 1, 0, 32'h0});
    vecs.push_back('{1, 32'h100, 0, 1, 0, 0, 32'h0});
    vecs.push_back('{0, 32'h0,   0, 1, 0, 1, 32'h100});
    vecs.push_back('{0, 32'h0,   0, 1, 0, 1, 32'h104});
    vecs.push_back('{0, 32'h0,   0, 0, 1, 1, 32'h108});
    vecs.push_back('{0, 32'h0,   0, 0, 1, 1, 32'h108});
    vecs.push_back('{0, 32'h0,   0, 0, 1, 1, 32'h108});
    vecs.push_back('{0, 32'h0,   0, 1, 1, 1, 32'h108});
    vecs.push_back('{0, 32'h0,   0, 1, 1, 1, 32'h10C});

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].doReset) doReset(vecs[i].pcStart);
      applyStimulus(vecs[i].take, vecs[i].gnt);
      checkOutput($sformatf("vec%0d instr_valid", i), {31'b0, sValid}, {31'b0, vecs[i].expValid});
      checkOutput($sformatf("vec%0d imem_req", i), {31'b0, sReq}, {31'b0, vecs[i].expReq});
      if (vecs[i].expReq) checkOutput($sformatf("vec%0d imem_addr", i), sAddr, vecs[i].expAddr);
      if (vecs[i].expValid) checkOutput($sformatf("vec%0d NextInstr", i), sData, memWord(sPc));
    end

    // Asynchronous reset with three words queued, then restart from 0x100.
    doReset(32'h300);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1);
    reset = 1'b0;
    memQ.delete();
    bus.imem_rvalid = 1'b0;
    bus.imem_gnt = 1'b0;
    #1;
    checkOutput("rst instr_valid", {31'b0, bus.instr_valid}, 32'h0);
    checkOutput("rst hold", {31'b0, bus.hold}, 32'h1);
    checkOutput("rst imem_req", {31'b0, bus.imem_req}, 32'h0);
    checkOutput("rst imem_addr", bus.imem_addr, 32'h0);
    checkOutput("rst NextInstr", bus.NextInstr, 32'h0);
    releaseReset(32'h100);
    applyStimulus(1'b0, 1'b1);
    checkOutput("boot imem_req", {31'b0, sReq}, 32'h0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("restart imem_req", {31'b0, sReq}, 32'h1);
    checkOutput("restart imem_addr", sAddr, 32'h100);

    // Redirect to 0x200 while 0x100 and 0x104 are still in flight (latency 3).
    latency = 3;
    doReset(32'h100);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1);
    pcReg = 32'h200;
    bus.PCcompress = pcReg;
    applyStimulus(1'b0, 1'b1);
    checkOutput("redir detect instr_valid", {31'b0, sValid}, 32'h0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("redir flush imem_req", {31'b0, sReq}, 32'h0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("redir refetch imem_req", {31'b0, sReq}, 32'h1);
    checkOutput("redir refetch imem_addr", sAddr, 32'h200);
    seen = 1'b0;
    firstValid = -1;
    for (int i = 0; i < 20 && !seen; i++) begin
      applyStimulus(1'b0, 1'b1);
      if (sValid) begin
        seen = 1'b1;
        firstValid = cyc - 1;
        checkOutput("redir first NextInstr", sData, memWord(32'h200));
      end
    end
    checkOutput("redir first valid cycle", firstValid, 32'd9);

    // Address wrap from the top of memory to zero.
    latency = 1;
    doReset(32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1);
    checkOutput("wrap addr0", sAddr, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b1);
    checkOutput("wrap addr1", sAddr, 32'h0000_0000);
    applyStimulus(1'b1, 1'b1);
    checkOutput("wrap valid0", {31'b0, sValid}, 32'h1);
    checkOutput("wrap data0", sData, memWord(32'hFFFF_FFFC));
    applyStimulus(1'b1, 1'b1);
    checkOutput("wrap valid1", {31'b0, sValid}, 32'h1);
    checkOutput("wrap pc1", sPc, 32'h0);
    checkOutput("wrap data1", sData, memWord(32'h0));

    // Randomized decompressor: sequential takes, occasional jumps, random grants.
    for (int round = 0; round < 4; round++) begin
      latency = $urandom_range(1, 3);
      doReset(32'h1000 + 32'($urandom_range(0, 63)) * 32'd4);
      prevReq = 1'b0;
      prevGnt = 1'b0;
      prevAddr = '0;
      waitCnt = 0;
      sinceJump = 10;
      for (int n = 0; n < 400; n++) begin
        if ($urandom_range(0, 19) == 0) begin
          pcReg = 32'h1000 + 32'($urandom_range(0, 63)) * 32'd4;
          bus.PCcompress = pcReg;
          sinceJump = 0;
        end
        take = ($urandom_range(0, 9) < 7);
        gnt = ($urandom_range(0, 3) != 0);
        applyStimulus(take, gnt);
        checkOutput($sformatf("rnd%0d.%0d hold", round, n), {31'b0, sHold}, {31'b0, !sValid});
        if (sValid) checkOutput($sformatf("rnd%0d.%0d NextInstr", round, n), sData, memWord(sPc));
        if (prevReq && !prevGnt && sinceJump >= 2) begin
          checkOutput($sformatf("rnd%0d.%0d req held", round, n), {31'b0, sReq}, 32'h1);
          checkOutput($sformatf("rnd%0d.%0d addr held", round, n), sAddr, prevAddr);
        end
        waitCnt = sValid ? 0 : waitCnt + 1;
        if (waitCnt > 40) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL rnd%0d.%0d liveness: got %0d cycles without instr_valid, expected at most 40", round, n, waitCnt);
          waitCnt = 0;
        end
        prevReq = sReq;
        prevGnt = gnt;
        prevAddr = sAddr;
        sinceJump++;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
